// File: rtl/dmem_dp_be.sv
// rtl/dmem_dp_be.sv - dual-port data memory, port 0 byte-enable read/write, port 1 read-only
module dmem_dp_be #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DATA_W/8-1:0]   be0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wd0,
    output logic                  rvalid0,
    output logic [DATA_W-1:0]     rd0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [ADDR_W-1:0]     addr1,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rd1,
    output logic                  err1
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IDX = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX-1:0]    idx0, idx1;
    logic              fault0, fault1;
    logic              wr0;
    logic [DATA_W-1:0] fwd1_d;

    logic              rvalid0_q, err0_q, rvalid1_q, err1_q;
    logic [DATA_W-1:0] rd0_q, rd1_q;

    // Decode word index and fault (misaligned or beyond the array) for both ports.
    always_comb begin
        idx0   = addr0[OFF +: IDX];
        idx1   = addr1[OFF +: IDX];
        fault0 = ((addr0 & OFF_MASK) != '0) || ((addr0 >> (OFF + IDX)) != '0);
        fault1 = ((addr1 & OFF_MASK) != '0) || ((addr1 >> (OFF + IDX)) != '0);
        wr0    = req0 && we0 && !fault0 && !rst;
    end

    // Port-1 read word with same-cycle port-0 write lanes forwarded in (write-first).
    always_comb begin
        fwd1_d = mem[idx1];
        if (wr0 && (idx0 == idx1)) begin
            for (int i = 0; i < NB; i++) begin
                if (be0[i]) fwd1_d[8*i +: 8] = wd0[8*i +: 8];
            end
        end
    end

    // Array update: only enabled lanes of a non-faulting, non-reset port-0 write.
    always_ff @(posedge clk) begin
        if (wr0) begin
            for (int i = 0; i < NB; i++) begin
                if (be0[i]) mem[idx0][8*i +: 8] <= wd0[8*i +: 8];
            end
        end
    end

    // Port-0 response: read-first data (old word), zeroed data on fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            err0_q    <= 1'b0;
            rd0_q     <= '0;
        end else if (req0) begin
            rvalid0_q <= 1'b1;
            err0_q    <= fault0;
            rd0_q     <= fault0 ? '0 : mem[idx0];
        end else begin
            rvalid0_q <= 1'b0;
            err0_q    <= 1'b0;
        end
    end

    // Port-1 response: forwarded word, zeroed data on fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
            rd1_q     <= '0;
        end else if (req1) begin
            rvalid1_q <= 1'b1;
            err1_q    <= fault1;
            rd1_q     <= fault1 ? '0 : fwd1_d;
        end else begin
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
        end
    end

    // A response registered just before reset is suppressed while reset is held.
    always_comb begin
        rvalid0 = rvalid0_q && !rst;
        err0    = err0_q && !rst;
        rd0     = rd0_q;
        rvalid1 = rvalid1_q && !rst;
        err1    = err1_q && !rst;
        rd1     = rd1_q;
    end

endmodule

// File: tb/tb_dmem_dp_be.sv
// tb/tb_dmem_dp_be.sv - table-driven scoreboard bench for dmem_dp_be
module tb_dmem_dp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1;
    logic [3:0]  be0;
    logic [31:0] addr0, wd0, addr1;
    logic        rvalid0, err0, rvalid1, err1;
    logic [31:0] rd0, rd1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_dp_be #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wd0(wd0),
        .rvalid0(rvalid0), .rd0(rd0), .err0(err0),
        .req1(req1), .addr1(addr1),
        .rvalid1(rvalid1), .rd1(rd1), .err1(err1)
    );

    typedef struct {
        string       name;
        logic        req0;
        logic        we0;
        logic [3:0]  be0;
        logic [31:0] addr0;
        logic [31:0] wd0;
        logic        req1;
        logic [31:0] addr1;
        logic        chk_rd0;
        logic [31:0] x_rd0;
        logic        x_err0;
        logic [31:0] x_rd1;
        logic        x_err1;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic vec_t mk(string n, logic r0, logic w0, logic [3:0] b0, logic [31:0] a0,
                                logic [31:0] d0, logic r1, logic [31:0] a1, logic c0,
                                logic [31:0] xr0, logic xe0, logic [31:0] xr1, logic xe1);
        vec_t v;
        v.name = n; v.req0 = r0; v.we0 = w0; v.be0 = b0; v.addr0 = a0; v.wd0 = d0;
        v.req1 = r1; v.addr1 = a1; v.chk_rd0 = c0;
        v.x_rd0 = xr0; v.x_err0 = xe0; v.x_rd1 = xr1; v.x_err1 = xe1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic check_resp();
        exp_t e;
        if (rvalid0) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL unexpected_rvalid0: got 1 expected 0");
            end else begin
                e = q0.pop_front();
                chk({e.name, "_err0"}, {31'd0, err0}, {31'd0, e.err});
                if (e.chk_rd) chk({e.name, "_rd0"}, rd0, e.rd);
            end
        end else begin
            chk("idle_err0", {31'd0, err0}, 32'd0);
        end
        if (q0.size() != 0) begin
            total++;
            $display("FAIL missing_rvalid0 %s: got 0 expected 1", q0[0].name);
            q0.delete();
        end
        if (rvalid1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL unexpected_rvalid1: got 1 expected 0");
            end else begin
                e = q1.pop_front();
                chk({e.name, "_err1"}, {31'd0, err1}, {31'd0, e.err});
                chk({e.name, "_rd1"}, rd1, e.rd);
            end
        end
        if (q1.size() != 0) begin
            total++;
            $display("FAIL missing_rvalid1 %s: got 0 expected 1", q1[0].name);
            q1.delete();
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        req0 = v.req0; we0 = v.we0; be0 = v.be0; addr0 = v.addr0; wd0 = v.wd0;
        req1 = v.req1; addr1 = v.addr1;
        if (v.req0) begin
            e.name = v.name; e.chk_rd = v.chk_rd0; e.rd = v.x_rd0; e.err = v.x_err0;
            q0.push_back(e);
        end
        if (v.req1) begin
            e.name = v.name; e.chk_rd = 1'b1; e.rd = v.x_rd1; e.err = v.x_err1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        check_resp();
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk("wr10_full",   1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 0, 0,       0, 0,            0, 0,            0);
        vecs[1]  = mk("rd10",        1, 0, 4'h0, 32'h10,   0,            0, 0,       1, 32'hDEADBEEF, 0, 0,            0);
        vecs[2]  = mk("wr20_full",   1, 1, 4'hF, 32'h20,   32'h11223344, 0, 0,       0, 0,            0, 0,            0);
        vecs[3]  = mk("wr20_be5",    1, 1, 4'h5, 32'h20,   32'hAABBCCDD, 0, 0,       1, 32'h11223344, 0, 0,            0);
        vecs[4]  = mk("rd20_merge",  1, 0, 4'hF, 32'h20,   0,            0, 0,       1, 32'h11BB33DD, 0, 0,            0);
        vecs[5]  = mk("wr20_be0",    1, 1, 4'h0, 32'h20,   32'hFFFFFFFF, 0, 0,       1, 32'h11BB33DD, 0, 0,            0);
        vecs[6]  = mk("rd20_noop",   1, 0, 4'h0, 32'h20,   0,            0, 0,       1, 32'h11BB33DD, 0, 0,            0);
        vecs[7]  = mk("wr22_misal",  1, 1, 4'hF, 32'h22,   32'h55555555, 0, 0,       1, 0,            1, 0,            0);
        vecs[8]  = mk("wr1000_oor",  1, 1, 4'hF, 32'h1000, 32'h66666666, 0, 0,       1, 0,            1, 0,            0);
        vecs[9]  = mk("rd20_after",  1, 0, 4'h0, 32'h20,   0,            0, 0,       1, 32'h11BB33DD, 0, 0,            0);
        vecs[10] = mk("p1_misal",    0, 0, 4'h0, 0,        0,            1, 32'h3,   0, 0,            0, 0,            1);
        vecs[11] = mk("wr40_zero",   1, 1, 4'hF, 32'h40,   32'h00000000, 1, 32'h10,  0, 0,            0, 32'hDEADBEEF, 0);
        vecs[12] = mk("collide40",   1, 1, 4'hC, 32'h40,   32'hCAFEF00D, 1, 32'h40,  1, 32'h00000000, 0, 32'hCAFE0000, 0);
        vecs[13] = mk("rd40_both",   1, 0, 4'h0, 32'h40,   0,            1, 32'h20,  1, 32'hCAFE0000, 0, 32'h11BB33DD, 0);
        vecs[14] = mk("p1_oor",      0, 0, 4'h0, 0,        0,            1, 32'h1000,0, 0,            0, 0,            1);
        vecs[15] = mk("wrffc_last",  1, 1, 4'hF, 32'hFFC,  32'h0BADCAFE, 0, 0,       0, 0,            0, 0,            0);
        vecs[16] = mk("rdffc_p1",    1, 0, 4'h0, 32'h10,   0,            1, 32'hFFC, 1, 32'hDEADBEEF, 0, 32'h0BADCAFE, 0);
        vecs[17] = mk("p1_wr_b2b",   1, 1, 4'h3, 32'h40,   32'h1234BEEF, 1, 32'h40,  1, 32'hCAFE0000, 0, 32'hCAFEBEEF, 0);

        rst = 1'b1; req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wd0 = 0; req1 = 0; addr1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        apply(mk("wr0_pre", 1, 1, 4'hF, 32'h0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0));

        // Requests during reset must be dropped and produce no response.
        rst = 1'b1; req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 0; wd0 = 32'hFFFFFFFF;
        req1 = 1; addr1 = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
            chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
            chk("rst_rd0", rd0, 32'd0);
            chk("rst_rd1", rd1, 32'd0);
            chk("rst_err0", {31'd0, err0}, 32'd0);
            chk("rst_err1", {31'd0, err1}, 32'd0);
        end
        rst = 1'b0;
        apply(mk("rd0_post_rst", 1, 0, 4'h0, 32'h0, 0, 1, 32'h0, 1, 32'h12345678, 0, 32'h12345678, 0));

        for (int i = 0; i < 18; i++) apply(vecs[i]);

        // Outputs hold across an idle cycle.
        apply(mk("rd20_hold", 1, 0, 4'h0, 32'h20, 0, 0, 0, 1, 32'h11BB33DD, 0, 0, 0));
        apply(mk("idle", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("hold_rd0", rd0, 32'h11BB33DD);

        // Reset in the response cycle of a read cancels it; a write presented with reset is dropped.
        req0 = 1; we0 = 0; be0 = 0; addr0 = 32'h10; req1 = 0;
        @(posedge clk);
        #1;
        rst = 1'b1; we0 = 1; be0 = 4'hF; wd0 = 32'h0;
        #1;
        chk("midrst_rvalid0_cancel", {31'd0, rvalid0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 0; we0 = 0;
        #1;
        chk("midrst_rvalid0_after", {31'd0, rvalid0}, 32'd0);
        chk("midrst_rd0_zero", rd0, 32'd0);
        apply(mk("rd10_after_rst", 1, 0, 4'h0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
